mii_tx_framer: RTL and testbench
================================

// Module: mii_tx_framer
// PURPOSE
// - Transmit-side counterpart of the nibble RX path: takes a byte stream with valid/ready/last
//   and drives 4-bit MII TX (TX_D/TX_EN) at the TX_CLK nibble rate (25 MHz).
// - Adds preamble/SFD, optional minimum-length padding, and a computed CRC32 FCS; enforces IFG.
// - Sits between the arbiter-selected frame source (ARP answer / data reporter) and TX pins.
// PARAMETERS
// - PREAMBLE_BYTES  7     count of 0x55 bytes before the SFD (0xD5)
// - MIN_FRAME_BYTES 60    minimum frame length before FCS; used only with MII_TX_PAD_EN
// - IFG_BYTES       12    idle bytes (2*IFG_BYTES clocks) forced after every frame/abort
// PORTS
// - clock      in   1  TX nibble clock; all logic on posedge
// - aclr       in   1  async reset, active-high
// - s_data     in   8  frame byte (dst MAC first, no preamble, no FCS)
// - s_valid    in   1  s_data valid
// - s_last     in   1  s_data is the last payload byte of the frame
// - s_ready    out  1  byte captured this cycle when s_valid & s_ready
// - tx_d       out  4  MII data, low nibble of each byte first
// - tx_en      out  1  MII enable
// - busy       out  1  high from frame start through end of IFG
// - frame_done out  1  1-cycle pulse on the cycle after the last FCS nibble
// - err_underrun out 1 1-cycle pulse when a frame is aborted for missing data
// BEHAVIOUR
// - Reset (async, immediate): tx_d=0, tx_en=0, s_ready=0, busy=0, pulses 0, state IDLE, crc=FFFFFFFF.
// - All outputs registered. Every byte takes 2 clocks: phase L (low nibble), phase H (high nibble).
// - States: IDLE -> PRE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE.
// - IDLE: s_ready=0; s_valid=1 at cycle N -> tx_en=1, tx_d=4'h5 at N+1 (PRE begins), busy=1.
// - PRE: PREAMBLE_BYTES*2 nibbles of 4'h5. SFD: nibbles 4'h5 then 4'hD.
// - s_ready=1 only in the H phase of SFD and of each DATA byte not flagged last; the byte
//   accepted there is sent starting next cycle (L phase). No bubbles inside a frame.
// - DATA: byte accepted with s_last=1 -> after its H nibble go to PAD (if enabled and
//   byte_count<MIN_FRAME_BYTES) else FCS. s_ready stays 0 after last until next IDLE.
// - Underrun: s_valid=0 at a required H-phase handshake -> tx_en drops next cycle (frame
//   truncated, no FCS), err_underrun pulses, go IFG. Bytes offered later start a new frame.
// - byte_count: 11 bits, counts DATA+PAD bytes; saturates at 2047 (no other effect).
// - CRC32: reflected poly 0xEDB88320, init 0xFFFFFFFF, updated per byte (or per nibble, bit-exact)
//   over DATA and PAD bytes only; FCS = ~crc sent LSB-first: byte0=~crc[7:0], nibble
//   order crc[3:0],crc[7:4],...,crc[31:28]; 8 nibbles.
// - FCS last nibble -> tx_en=0 next cycle, frame_done pulses same cycle, IFG starts.
// - IFG: tx_en=0, tx_d=0, 2*IFG_BYTES clocks, busy=1; s_valid ignored; then IDLE, busy=0.
// - crc reloaded to 0xFFFFFFFF on IDLE entry; aclr mid-frame aborts with no pulses.
// CONFIGURATION
// - MII_TX_PAD_EN defined: frames with fewer than MIN_FRAME_BYTES data bytes are padded with
//   0x00 bytes (included in CRC) up to MIN_FRAME_BYTES before FCS.
// - MII_TX_PAD_EN undefined: no PAD state; FCS directly follows the last data byte regardless
//   of length; MIN_FRAME_BYTES unused.
// TESTING
// - PAD off, payload ASCII "123456789" (9 bytes) -> 14x5,5,D, data nibbles 1,3,2,3,..., FCS
//   bytes 26 39 F4 CB (nibbles 6,2,9,3,4,F,B,C); tx_en high 2*(8+9+4)=42 cycles.
// - PAD on, 42-byte ARP reply -> 18 bytes 0x00 after data, 60+4 bytes after SFD (tx_en 144
//   cycles); reflected CRC register over data+pad+FCS = 0xDEBB20E3 in bench model.
// - Underrun: drop s_valid at byte 10 of 64 -> tx_en low next cycle, err_underrun 1 cycle,
//   no frame_done, busy stays 1 for 24 IFG clocks.
// - Back-to-back: second frame valid during IFG -> s_ready=0, next tx_en rises exactly
//   24 clocks after first frame's tx_en fall +1 cycle.
// - aclr asserted mid-DATA -> tx_en/s_ready/busy 0 asynchronously; new frame after
//   release starts with clean preamble and correct FCS.
// - Minimum 1-byte frame, PAD off: s_ready never asserted after last; 1+4 bytes after SFD.

Source files
------------

// File: rtl/mii_tx_framer.sv
// mii_tx_framer
//   Converts a byte stream (valid/ready/last) into 4-bit MII TX nibbles, one nibble per clock.
//   Frame on the wire: PREAMBLE_BYTES x 0x55, SFD 0xD5, payload, optional 0x00 pad, CRC32 FCS.
//   After every frame or abort, 2*IFG_BYTES idle clocks are forced before the next frame.
//   The low nibble of every byte is sent first.
//   Build option: define MII_TX_PAD_EN to pad frames shorter than MIN_FRAME_BYTES with 0x00
//   bytes (included in the CRC). Without it there is no pad state and MIN_FRAME_BYTES is absent.
// Ports
//   clock        TX nibble clock (25 MHz), all logic on posedge
//   aclr         asynchronous reset, active-high
//   s_data       frame byte (dst MAC first, no preamble, no FCS)
//   s_valid      s_data valid
//   s_last       s_data is the last payload byte
//   s_ready      byte taken on this cycle when s_valid & s_ready
//   tx_d         MII TX data nibble
//   tx_en        MII TX enable
//   busy         high from frame start through the end of the inter-frame gap
//   frame_done   1-cycle pulse on the cycle after the last FCS nibble
//   err_underrun 1-cycle pulse when a frame is cut short for lack of data
module mii_tx_framer #(
  parameter int unsigned PREAMBLE_BYTES  = 7,
`ifdef MII_TX_PAD_EN
  parameter int unsigned MIN_FRAME_BYTES = 60,
`endif
  parameter int unsigned IFG_BYTES       = 12
) (
  input  logic       clock,
  input  logic       aclr,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] tx_d,
  output logic       tx_en,
  output logic       busy,
  output logic       frame_done,
  output logic       err_underrun
);

  localparam logic [15:0] PreLast = 16'(2 * PREAMBLE_BYTES - 1);
  localparam logic [15:0] IfgLast = 16'(2 * IFG_BYTES - 1);

`ifdef MII_TX_PAD_EN
  localparam logic [10:0] MinBytes = 11'(MIN_FRAME_BYTES);
  typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg} state_e;
`else
  typedef enum logic [2:0] {StIdle, StPre, StSfd, StData, StFcs, StIfg} state_e;
`endif

  // Reflected CRC32 (poly 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // state_q/phase_q/cnt_q describe the nibble currently on tx_d.
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;  // 0: low nibble, 1: high nibble
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d;
  logic [3:0]  tx_d_q, tx_d_d;
  logic        tx_en_q, tx_en_d;
  logic        s_ready_q, s_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
`ifdef MII_TX_PAD_EN
  logic [10:0] bc_q, bc_d;  // DATA+PAD bytes, saturating
  logic        start_pad;
`endif

  logic [31:0] fcs;
  logic [2:0]  nib_idx;
  logic        take_byte;
  logic        start_fcs;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    byte_d    = byte_q;
    last_d    = last_q;
    crc_d     = crc_q;
    tx_d_d    = 4'h0;
    tx_en_d   = 1'b0;
    s_ready_d = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    err_d     = 1'b0;
    take_byte = 1'b0;
    start_fcs = 1'b0;
    fcs       = ~crc_q;
    nib_idx   = cnt_q[2:0] + 3'd1;
`ifdef MII_TX_PAD_EN
    bc_d      = bc_q;
    start_pad = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (s_valid) begin
          state_d = StPre;
          cnt_d   = '0;
          tx_en_d = 1'b1;
          tx_d_d  = 4'h5;
          busy_d  = 1'b1;
        end
      end
      StPre: begin
        tx_en_d = 1'b1;
        tx_d_d  = 4'h5;
        if (cnt_q == PreLast) begin
          state_d = StSfd;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StSfd: begin
        if (!phase_q) begin
          tx_en_d   = 1'b1;
          tx_d_d    = 4'hD;
          phase_d   = 1'b1;
          s_ready_d = 1'b1;
        end else begin
          take_byte = 1'b1;
        end
      end
      StData: begin
        if (!phase_q) begin
          tx_en_d   = 1'b1;
          tx_d_d    = byte_q[7:4];
          phase_d   = 1'b1;
          s_ready_d = !last_q;
        end else if (!last_q) begin
          take_byte = 1'b1;
        end else begin
`ifdef MII_TX_PAD_EN
          if (bc_q < MinBytes) start_pad = 1'b1;
          else                 start_fcs = 1'b1;
`else
          start_fcs = 1'b1;
`endif
        end
      end
`ifdef MII_TX_PAD_EN
      StPad: begin
        tx_en_d = 1'b1;
        if (!phase_q)              phase_d   = 1'b1;
        else if (bc_q < MinBytes)  start_pad = 1'b1;
        else                       start_fcs = 1'b1;
      end
`endif
      StFcs: begin
        if (cnt_q[2:0] == 3'd7) begin
          state_d = StIfg;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          tx_en_d = 1'b1;
          tx_d_d  = fcs[{nib_idx, 2'b00} +: 4];
        end
      end
      StIfg: begin
        if (cnt_q == IfgLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          crc_d   = '1;
`ifdef MII_TX_PAD_EN
          bc_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // H-phase handshake: either the next byte is there or the frame is cut here.
    if (take_byte) begin
      if (s_valid) begin
        state_d = StData;
        phase_d = 1'b0;
        byte_d  = s_data;
        last_d  = s_last;
        tx_en_d = 1'b1;
        tx_d_d  = s_data[3:0];
        crc_d   = crc_byte(crc_q, s_data);
`ifdef MII_TX_PAD_EN
        if (bc_q != 11'h7FF) bc_d = bc_q + 11'd1;
`endif
      end else begin
        state_d = StIfg;
        cnt_d   = '0;
        err_d   = 1'b1;
      end
    end

`ifdef MII_TX_PAD_EN
    if (start_pad) begin
      state_d = StPad;
      phase_d = 1'b0;
      tx_en_d = 1'b1;
      crc_d   = crc_byte(crc_q, 8'h00);
      if (bc_q != 11'h7FF) bc_d = bc_q + 11'd1;
    end
`endif

    if (start_fcs) begin
      state_d = StFcs;
      cnt_d   = '0;
      tx_en_d = 1'b1;
      tx_d_d  = fcs[3:0];
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      crc_q     <= '1;
      tx_d_q    <= '0;
      tx_en_q   <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef MII_TX_PAD_EN
      bc_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      crc_q     <= crc_d;
      tx_d_q    <= tx_d_d;
      tx_en_q   <= tx_en_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef MII_TX_PAD_EN
      bc_q      <= bc_d;
`endif
    end
  end

  assign tx_d         = tx_d_q;
  assign tx_en        = tx_en_q;
  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Testbench for mii_tx_framer: random and directed frames checked nibble-by-nibble against a
// frame-level model (expected wire nibbles, s_ready slots, lengths, pulses, gap timing).
module tb_mii_tx_framer;

  localparam int PreNibs = 16;
  localparam int IfgClks = 24;
`ifdef MII_TX_PAD_EN
  localparam int MinBytes = 60;
  localparam int Len9     = 144;
  localparam int Len1     = 144;
  localparam int Len42    = 144;
`else
  localparam int MinBytes = 0;
  localparam int Len9     = 42;
  localparam int Len1     = 26;
  localparam int Len42    = 108;
`endif

  logic       clock   = 1'b0;
  logic       aclr    = 1'b1;
  logic [7:0] s_data  = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last  = 1'b0;
  logic       s_ready;
  logic [3:0] tx_d;
  logic       tx_en;
  logic       busy;
  logic       frame_done;
  logic       err_underrun;

  mii_tx_framer dut (
    .clock        (clock),
    .aclr         (aclr),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .tx_d         (tx_d),
    .tx_en        (tx_en),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_underrun (err_underrun)
  );

  always #20 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_nib[$];
  bit         exp_rdy[$];
  int         exp_len[$];
  bit         exp_abort[$];
  logic [7:0] fb[$];
  logic [7:0] crc_buf[$];
  logic [3:0] cap[$];
  int         last_len = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         nib_cnt = 0;
  int         ifg_left = 0;
  bit         in_frame = 1'b0;
  bit         b2b_armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bitwise CRC32 register over crc_buf (no final inversion).
  function automatic logic [31:0] crc_value();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (crc_buf[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ crc_buf[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                      c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic void push_nib(input logic [3:0] n, input bit r);
    exp_nib.push_back(n);
    exp_rdy.push_back(r);
  endfunction

  // Expected wire image of frame fb[0..n-1]; stop>=0 means byte 'stop' is never offered.
  function automatic void model_frame(input int n, input int stop);
    logic [31:0] fcs;
    for (int k = 0; k < 15; k++) push_nib(4'h5, 1'b0);
    push_nib(4'hD, 1'b1);
    if (stop >= 0) begin
      for (int i = 0; i < stop; i++) begin
        push_nib(fb[i][3:0], 1'b0);
        push_nib(fb[i][7:4], 1'b1);
      end
      exp_len.push_back(PreNibs + 2 * stop);
      exp_abort.push_back(1'b1);
      return;
    end
    crc_buf.delete();
    for (int i = 0; i < n; i++) crc_buf.push_back(fb[i]);
    while (crc_buf.size() < MinBytes) crc_buf.push_back(8'h00);
    foreach (crc_buf[i]) begin
      push_nib(crc_buf[i][3:0], 1'b0);
      push_nib(crc_buf[i][7:4], i < n - 1);
    end
    fcs = ~crc_value();
    for (int k = 0; k < 8; k++) push_nib(fcs[4 * k +: 4], 1'b0);
    exp_len.push_back(PreNibs + 2 * crc_buf.size() + 8);
    exp_abort.push_back(1'b0);
  endfunction

  // Source: offers fb[] bytes; drops s_valid at byte 'stop' to force an underrun.
  task automatic drive_frame(input int n, input int stop, input bit wait_idle);
    int i;
    int budget;
    int w;
    bit hs;
    i = 0;
    budget = 0;
    model_frame(n, stop);
    @(negedge clock);
    s_valid = 1'b1;
    s_data  = fb[0];
    s_last  = (n == 1);
    forever begin
      hs = s_valid && s_ready;
      @(negedge clock);
      if (aclr) begin
        s_valid = 1'b0;
        return;
      end
      if (hs) i++;
      budget++;
      if (budget > 4000) begin
        chk("drive_timeout", budget, 0);
        s_valid = 1'b0;
        return;
      end
      if (i == n || i == stop) begin
        s_valid = 1'b0;
        break;
      end
      s_data = fb[i];
      s_last = (i == n - 1);
    end
    if (wait_idle) begin
      w = 0;
      while (busy && w < 4000) begin
        @(negedge clock);
        w++;
      end
      if (busy) chk("idle_timeout", busy, 0);
      @(negedge clock);
    end
  endtask

  task automatic check_residue(input string name);
    crc_buf.delete();
    for (int j = 0; PreNibs + 2 * j + 1 < cap.size(); j++)
      crc_buf.push_back({cap[PreNibs + 2 * j + 1], cap[PreNibs + 2 * j]});
    chk(name, crc_value(), 32'hDEBB20E3);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clock) begin : mon
    bit have;
    bit ab;
    cyc++;
    if (aclr) begin
      chk("rst_tx_en", tx_en, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_d", tx_d, 0);
      chk("rst_pulses", {frame_done, err_underrun}, 0);
      exp_nib.delete();
      exp_rdy.delete();
      exp_len.delete();
      exp_abort.delete();
      in_frame  = 1'b0;
      ifg_left  = 0;
      b2b_armed = 1'b0;
    end else if (tx_en) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        nib_cnt  = 0;
        cap.delete();
        have = exp_len.size() > 0;
        chk("frame_expected", have, 1);
        chk("start_after_ifg", ifg_left, 0);
        if (b2b_armed) begin
          chk("b2b_gap", cyc - fall_cyc, 25);
          b2b_armed = 1'b0;
        end
      end
      nib_cnt++;
      cap.push_back(tx_d);
      chk("busy_in_frame", busy, 1);
      chk("pulses_in_frame", {frame_done, err_underrun}, 0);
      have = exp_nib.size() > 0;
      if (!have) chk("nibble_available", have, 1);
      else begin
        chk("tx_d", tx_d, exp_nib.pop_front());
        chk("s_ready", s_ready, exp_rdy.pop_front());
      end
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        fall_cyc = cyc;
        last_len = nib_cnt;
        ifg_left = IfgClks;
        have = exp_len.size() > 0;
        if (!have) chk("frame_accounted", have, 1);
        else begin
          ab = exp_abort.pop_front();
          chk("frame_len", nib_cnt, exp_len.pop_front());
          chk("frame_done", frame_done, !ab);
          chk("err_underrun", err_underrun, ab);
        end
      end else begin
        chk("no_pulse_idle", {frame_done, err_underrun}, 0);
      end
      chk("tx_d_idle", tx_d, 0);
      chk("s_ready_idle", s_ready, 0);
      if (ifg_left > 0) begin
        chk("busy_ifg", busy, 1);
        ifg_left--;
      end else begin
        chk("busy_idle", busy, 0);
      end
    end
  end

  task automatic rand_fill(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  initial begin : main
    logic [31:0] fcs_got;
    int n;
    int stop;
    repeat (3) @(negedge clock);
    #3 aclr = 1'b0;
    repeat (2) @(negedge clock);

    // "123456789": known CRC32 0xCBF43926
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'(32'h31 + i));
    crc_buf = fb;
    chk("model_crc_123456789", ~crc_value(), 32'hCBF43926);
    drive_frame(9, -1, 1'b1);
    chk("len_123456789", last_len, Len9);
`ifndef MII_TX_PAD_EN
    for (int k = 0; k < 8; k++) fcs_got[4 * k +: 4] = cap[34 + k];
    chk("fcs_literal", fcs_got, 32'hCBF43926);
`endif
    check_residue("residue_123456789");

    // Minimum 1-byte frame
    rand_fill(1);
    drive_frame(1, -1, 1'b1);
    chk("len_1byte", last_len, Len1);
    check_residue("residue_1byte");

    // 42-byte ARP-sized frame
    rand_fill(42);
    drive_frame(42, -1, 1'b1);
    chk("len_42byte", last_len, Len42);
    check_residue("residue_42byte");

    // Underrun at byte 10 of 64
    rand_fill(64);
    drive_frame(64, 10, 1'b1);
    chk("len_underrun", last_len, PreNibs + 20);

    // Back-to-back: second frame offered during the first frame's tail and IFG
    rand_fill(20);
    drive_frame(20, -1, 1'b0);
    b2b_armed = 1'b1;
    rand_fill(30);
    drive_frame(30, -1, 1'b1);
    check_residue("residue_b2b");

    // Asynchronous reset mid-DATA
    rand_fill(64);
    fork
      drive_frame(64, -1, 1'b0);
      begin
        repeat (40) @(negedge clock);
        #5;
        chk("pre_aclr_tx_en", tx_en, 1);
        aclr = 1'b1;
        #1;
        chk("aclr_tx_en", tx_en, 0);
        chk("aclr_s_ready", s_ready, 0);
        chk("aclr_busy", busy, 0);
      end
    join
    repeat (2) @(negedge clock);
    #3 aclr = 1'b0;
    @(negedge clock);
    rand_fill(25);
    drive_frame(25, -1, 1'b1);
    check_residue("residue_after_aclr");

    // Random frames, some truncated, some offered back-to-back
    for (int f = 0; f < 16; f++) begin
      n = $urandom_range(1, 80);
      stop = -1;
      if (n > 1 && $urandom_range(0, 3) == 0) stop = $urandom_range(1, n - 1);
      rand_fill(n);
      drive_frame(n, stop, (stop >= 0) || ($urandom_range(0, 1) == 1));
    end
    begin
      int w;
      w = 0;
      while (busy && w < 4000) begin
        @(negedge clock);
        w++;
      end
      if (busy) chk("final_idle_timeout", busy, 0);
    end
    repeat (4) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
